// File: rtl/mpu_pkg.sv
// Shared types and constants for the MPU matrix-multiply sequencer.
// Element (i,j) of a packed matrix starts at bit elem_idx(i,j).
package mpu_pkg;

  localparam int DIM    = 5;
  localparam int ELEM_W = 8;
  localparam int MAT_W  = DIM * DIM * ELEM_W;
  localparam int IDX_W  = 3;
  localparam int OFF_W  = $clog2(MAT_W);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    MAC,
    DONE
  } state_t;

  function automatic logic [OFF_W-1:0] elem_idx(
    input logic [IDX_W-1:0] i,
    input logic [IDX_W-1:0] j
  );
    return OFF_W'((int'(i) * DIM + int'(j)) * ELEM_W);
  endfunction

endpackage

// File: rtl/mpu_mac_unit.sv
// Combinational 8x8 multiply-accumulate: sum = acc + a*b.
// MPU_MUL_SAT_EN selects unsigned saturation instead of mod-256 wrap.
module mpu_mac_unit
  import mpu_pkg::*;
(
  input  logic [ELEM_W-1:0] acc,
  input  logic [ELEM_W-1:0] a,
  input  logic [ELEM_W-1:0] b,
  output logic [ELEM_W-1:0] sum,
  output logic              ovf
);

`ifdef MPU_MUL_SAT_EN
  logic [2*ELEM_W-1:0] full;

  assign full = {{ELEM_W{1'b0}}, acc} + a * b;
  assign ovf  = |full[2*ELEM_W-1:ELEM_W];
  assign sum  = ovf ? '1 : full[ELEM_W-1:0];
`else
  // Wrap mode never clamps, so it never flags.
  assign sum = acc + a * b;
  assign ovf = 1'b0;
`endif

endmodule

// File: rtl/mpu_mul_sequencer.sv
// Sequential n x n matrix multiply over one shared MAC unit.
// Optional MPU_MUL_SAT_EN saturates sums and flags it on error.
module mpu_mul_sequencer
  import mpu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       size,
  input  logic [MAT_W-1:0] matrix_a,
  input  logic [MAT_W-1:0] matrix_b,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [MAT_W-1:0] result
);

  state_t             state;
  logic [MAT_W-1:0]   a_q;
  logic [MAT_W-1:0]   b_q;
  logic [IDX_W-1:0]   n_q;
  logic [IDX_W-1:0]   i_q;
  logic [IDX_W-1:0]   j_q;
  logic [IDX_W-1:0]   k_q;
  logic [IDX_W-1:0]   nm1;
  logic [ELEM_W-1:0]  acc_q;
  logic [ELEM_W-1:0]  a_el;
  logic [ELEM_W-1:0]  b_el;
  logic [ELEM_W-1:0]  sum;
  logic               ovf;
  logic               sticky_q;
  logic               bad_size;

  assign nm1      = n_q - 1'b1;
  assign a_el     = a_q[elem_idx(i_q, k_q) +: ELEM_W];
  assign b_el     = b_q[elem_idx(k_q, j_q) +: ELEM_W];
  assign bad_size = (size == 8'd0) || (size > 8'(DIM));

  mpu_mac_unit u_mac (
    .acc (acc_q),
    .a   (a_el),
    .b   (b_el),
    .sum (sum),
    .ovf (ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      result   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      n_q      <= '0;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      acc_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_q <= matrix_a;
            b_q <= matrix_b;
            n_q <= size[IDX_W-1:0];
            if (bad_size) begin
              state <= DONE;
              done  <= 1'b1;
              error <= 1'b1;
            end else begin
              state <= CLEAR;
              busy  <= 1'b1;
            end
          end
        end
        CLEAR: begin
          result   <= '0;
          i_q      <= '0;
          j_q      <= '0;
          k_q      <= '0;
          acc_q    <= '0;
          sticky_q <= 1'b0;
          error    <= 1'b0;
          state    <= MAC;
        end
        MAC: begin
          sticky_q <= sticky_q | ovf;
          if (k_q != nm1) begin
            acc_q <= sum;
            k_q   <= k_q + 1'b1;
          end else begin
            result[elem_idx(i_q, j_q) +: ELEM_W] <= sum;
            acc_q <= '0;
            k_q   <= '0;
            if (j_q == nm1) begin
              j_q <= '0;
              i_q <= i_q + 1'b1;
              // Last dot product of the matrix just completed.
              if (i_q == nm1) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
                error <= sticky_q | ovf;
              end
            end else begin
              j_q <= j_q + 1'b1;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          error <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mpu_mul_sequencer.sv
// Scoreboard bench for mpu_mul_sequencer: directed plan plus random ops.
// Reference model is a plain triple loop; honours MPU_MUL_SAT_EN.
module tb_mpu_mul_sequencer;
  import mpu_pkg::*;

  typedef struct {
    logic [MAT_W-1:0] res;
    logic             err;
    int               done_at;
    int               busy_n;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [7:0]       size = 8'd0;
  logic [MAT_W-1:0] ma = '0;
  logic [MAT_W-1:0] mb = '0;
  logic             busy;
  logic             done;
  logic             error;
  logic [MAT_W-1:0] result;

  exp_t             q[$];
  exp_t             me;
  int               errors = 0;
  int               checks = 0;
  int               cyc = 0;
  int               busy_cnt = 0;
  logic [MAT_W-1:0] last_res = '0;

  mpu_mul_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .size     (size),
    .matrix_a (ma),
    .matrix_b (mb),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .result   (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [MAT_W-1:0] act,
                     input logic [MAT_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [MAT_W-1:0] set_el(
    input logic [MAT_W-1:0] m, input int i, input int j, input int v);
    logic [MAT_W-1:0] r;
    r = m;
    r[(i*DIM+j)*ELEM_W +: ELEM_W] = 8'(v);
    return r;
  endfunction

  function automatic int get_el(input logic [MAT_W-1:0] m,
                                input int i, input int j);
    logic [ELEM_W-1:0] v;
    v = m[(i*DIM+j)*ELEM_W +: ELEM_W];
    return int'(v);
  endfunction

  function automatic logic [MAT_W-1:0] fill(input int v);
    logic [MAT_W-1:0] r;
    r = '0;
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++)
        r = set_el(r, i, j, v);
    return r;
  endfunction

  function automatic logic [MAT_W-1:0] rnd_mat();
    logic [MAT_W-1:0] r;
    r = '0;
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++)
        r = set_el(r, i, j, int'($urandom_range(0, 255)));
    return r;
  endfunction

  // C = A*B over the n x n corner; everything outside stays 0.
  function automatic logic [MAT_W-1:0] model(
    input logic [MAT_W-1:0] a, input logic [MAT_W-1:0] b,
    input int n, output logic ov);
    logic [MAT_W-1:0] r;
    int acc;
    r  = '0;
    ov = 1'b0;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++) begin
        acc = 0;
        for (int k = 0; k < n; k++) begin
          acc = acc + get_el(a, i, k) * get_el(b, k, j);
`ifdef MPU_MUL_SAT_EN
          if (acc > 255) begin
            acc = 255;
            ov  = 1'b1;
          end
`else
          acc = acc % 256;
`endif
        end
        r = set_el(r, i, j, acc);
      end
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done at cycle %0d want none", cyc);
        end else begin
          me = q.pop_front();
          chk("result", result, me.res);
          chk("error", MAT_W'(error), MAT_W'(me.err));
          chk("done_cycle", MAT_W'(cyc), MAT_W'(me.done_at));
          chk("busy_cycles", MAT_W'(busy_cnt), MAT_W'(me.busy_n));
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic issue(input logic [7:0] sz,
                       input logic [MAT_W-1:0] a,
                       input logic [MAT_W-1:0] b);
    exp_t e;
    logic ov;
    int   n;
    n = int'(sz);
    @(negedge clk);
    start = 1'b1;
    size  = sz;
    ma    = a;
    mb    = b;
    e.done_at = cyc + 1;
    if (n >= 1 && n <= DIM) begin
      e.res      = model(a, b, n, ov);
      e.err      = ov;
      e.done_at += n*n*n + 1;
      e.busy_n   = n*n*n + 1;
      last_res   = e.res;
    end else begin
      e.res  = last_res;
      e.err  = 1'b1;
      e.busy_n = 0;
    end
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    ma    = rnd_mat();
    mb    = rnd_mat();
  endtask

  task automatic wait_done();
    int lim;
    lim = 0;
    while (q.size() != 0 && lim < 2000) begin
      @(negedge clk);
      lim++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: got no done after %0d cycles want done", lim);
      q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    logic [MAT_W-1:0] a;
    logic [MAT_W-1:0] b;

    repeat (3) @(negedge clk);
    chk("rst_busy", MAT_W'(busy), '0);
    chk("rst_done", MAT_W'(done), '0);
    chk("rst_error", MAT_W'(error), '0);
    chk("rst_result", result, '0);
    rst_n = 1'b1;

    a = set_el(fill(255), 0, 0, 3);
    b = set_el(fill(255), 0, 0, 4);
    issue(8'd1, a, b);
    wait_done();

    issue(8'd5, fill(1), fill(1));
    wait_done();

    issue(8'd2, fill(16), fill(16));
    wait_done();

    issue(8'd1, fill(7), fill(9));
    wait_done();
    issue(8'd0, rnd_mat(), rnd_mat());
    wait_done();
    issue(8'd6, rnd_mat(), rnd_mat());
    wait_done();

    a = rnd_mat();
    b = rnd_mat();
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        a = set_el(a, i, j, (i == j) ? 1 : 0);
        b = set_el(b, i, j, i*3 + j + 1);
      end
    issue(8'd3, a, b);
    repeat (4) @(negedge clk);
    start = 1'b1;
    size  = 8'd2;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    issue(8'd4, rnd_mat(), rnd_mat());
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", MAT_W'(busy), '0);
    chk("abort_done", MAT_W'(done), '0);
    chk("abort_error", MAT_W'(error), '0);
    chk("abort_result", result, '0);
    q.delete();
    last_res = '0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    issue(8'd2, rnd_mat(), rnd_mat());
    wait_done();

    for (int t = 0; t < 14; t++) begin
      issue(8'($urandom_range(0, 6)), rnd_mat(), rnd_mat());
      wait_done();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
